// File: rtl/usb_serial_pkg.sv
// usb_serial_pkg: shared constants and drain-FSM state encoding for the USB serial endpoints
package usb_serial_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    XFER  = 2'd2,
    FLUSH = 2'd3
  } out_state_e;
  localparam int FIFO_DEPTH_DEFAULT = 16;
  localparam int DATA_W = 8;
  localparam int PKT_CNT_W = 16;
endpackage

// File: rtl/usb_serial_out_ep_if.sv
// usb_serial_out_ep_if: OUT protocol engine, UART sink and status signals of the OUT endpoint
interface usb_serial_out_ep_if import usb_serial_pkg::*; #(
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) ();
  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  logic              out_ep_req;
  logic              out_ep_grant;
  logic              out_ep_data_avail;
  logic              out_ep_setup;
  logic              out_ep_acked;
  logic              out_ep_data_get;
  logic [DATA_W-1:0] out_ep_data;
  logic              out_ep_stall;
  logic              stall_req;
  logic [DATA_W-1:0] uart_data;
  logic              uart_valid;
  logic              uart_ready;
  logic [LW-1:0]     fifo_level;
  logic              setup_seen;
  logic [PKT_CNT_W-1:0] pkt_count;
  modport master (
    output out_ep_req, out_ep_data_get, out_ep_stall, uart_data, uart_valid,
           fifo_level, setup_seen, pkt_count,
    input  out_ep_grant, out_ep_data_avail, out_ep_setup, out_ep_acked,
           out_ep_data, stall_req, uart_ready
  );
  modport slave (
    input  out_ep_req, out_ep_data_get, out_ep_stall, uart_data, uart_valid,
           fifo_level, setup_seen, pkt_count,
    output out_ep_grant, out_ep_data_avail, out_ep_setup, out_ep_acked,
           out_ep_data, stall_req, uart_ready
  );
endinterface

// File: rtl/usb_serial_sync_fifo.sv
// usb_serial_sync_fifo: show-ahead circular FIFO with MSB-extended pointers
module usb_serial_sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   wr_en_i,
  input  logic [WIDTH-1:0]       wr_data_i,
  input  logic                   rd_en_i,
  output logic [WIDTH-1:0]       rd_data_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] level_o
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0] wptr_q, rptr_q;
  logic full, wr, rd;
  assign empty_o = wptr_q == rptr_q;
  assign full = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign rd = rd_en_i && !empty_o;
  // A full FIFO may still take a write in the cycle its head is popped
  assign wr = wr_en_i && (!full || rd);
  assign level_o = wptr_q - rptr_q;
  assign rd_data_o = mem_q[rptr_q[AW-1:0]];
  always_ff @(posedge clk) begin
    if (wr) mem_q[wptr_q[AW-1:0]] <= wr_data_i;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_q + {{AW{1'b0}}, wr};
      rptr_q <= rptr_q + {{AW{1'b0}}, rd};
    end
  end
  a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n) !(wr_en_i && full));
endmodule

// File: rtl/usb_serial_out_ep.sv
// usb_serial_out_ep: drains OUT packets from the protocol engine into a FIFO feeding a UART
module usb_serial_out_ep import usb_serial_pkg::*; #(
  parameter int FIFO_DEPTH   = FIFO_DEPTH_DEFAULT,
  parameter bit ENABLE_STALL = 1'b0
) (
  input logic                 clk,
  input logic                 reset_n,
  usb_serial_out_ep_if.master bus
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(FIFO_DEPTH);
  out_state_e state_q, state_d;
  logic inflight_q, setup_seen_q, setup_seen_d;
  logic [PKT_CNT_W-1:0] pkt_count_q, pkt_count_d;
  logic get, room, empty;
  // Reserve a slot for the byte still in flight so the FIFO can never overflow
  assign room = bus.fifo_level + {{(LW-1){1'b0}}, inflight_q} < DEPTH_L;
  assign get = state_q == XFER && bus.out_ep_grant && bus.out_ep_data_avail && room;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.out_ep_data_avail) state_d = REQ;
      REQ:     if (bus.out_ep_grant) state_d = XFER;
      XFER:    if (!bus.out_ep_data_avail || !bus.out_ep_grant) state_d = FLUSH;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    setup_seen_d = setup_seen_q || (inflight_q && bus.out_ep_setup);
    pkt_count_d = pkt_count_q + {{(PKT_CNT_W-1){1'b0}}, bus.out_ep_acked};
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      inflight_q   <= 1'b0;
      setup_seen_q <= 1'b0;
      pkt_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      inflight_q   <= get;
      setup_seen_q <= setup_seen_d;
      pkt_count_q  <= pkt_count_d;
    end
  end
  usb_serial_sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_W)) u_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .wr_en_i  (inflight_q && !bus.out_ep_setup),
    .wr_data_i(bus.out_ep_data),
    .rd_en_i  (bus.uart_ready),
    .rd_data_o(bus.uart_data),
    .empty_o  (empty),
    .level_o  (bus.fifo_level)
  );
  assign bus.out_ep_req      = state_q != IDLE;
  assign bus.out_ep_data_get = get;
  assign bus.uart_valid      = !empty;
  assign bus.setup_seen      = setup_seen_q;
  assign bus.pkt_count       = pkt_count_q;
  assign bus.out_ep_stall    = ENABLE_STALL && bus.stall_req;
endmodule

// File: doc/usb_serial_out_ep.md
USB_SERIAL_OUT_EP -- requirements
Module: usb_serial_out_ep

Interface
REQ-001 Parameter FIFO_DEPTH, default 16, receive FIFO depth in bytes; legal values are powers of two from 4 to 64.
REQ-002 Parameter ENABLE_STALL, default 0; when 0, out_ep_stall is tied low.
REQ-003 Port clk  in  1  sole clock; all logic samples on its rising edge.
REQ-004 Port reset_n  in  1  synchronous, active-low reset.
REQ-005 Port out_ep_req  out  1  bus request to the OUT arbiter.
REQ-006 Port out_ep_grant  in  1  arbiter grant; selects this endpoint's data inside the OUT protocol engine.
REQ-007 Port out_ep_data_avail  in  1  protocol engine holds at least one unread byte for this endpoint.
REQ-008 Port out_ep_setup  in  1  current packet arrived via a SETUP token.
REQ-009 Port out_ep_acked  in  1  single-cycle strobe when the protocol engine ACKs a packet to this endpoint.
REQ-010 Port out_ep_data_get  out  1  byte-read strobe to the protocol engine.
REQ-011 Port out_ep_data  in  8  registered read data; valid the cycle after out_ep_data_get.
REQ-012 Port out_ep_stall  out  1  endpoint stall request.
REQ-013 Port stall_req  in  1  local stall request; used only when ENABLE_STALL=1.
REQ-014 Port uart_data  out  8  head-of-FIFO byte.
REQ-015 Port uart_valid  out  1  FIFO not empty.
REQ-016 Port uart_ready  in  1  consumer accepts uart_data when uart_valid and uart_ready are both high.
REQ-017 Port fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
REQ-018 Port setup_seen  out  1  sticky flag: a SETUP-sourced byte was dropped.
REQ-019 Port pkt_count  out  16  count of acked packets, wrapping.

Function
REQ-020 Drain FSM states: IDLE, REQ, XFER, FLUSH.
REQ-021 IDLE -> REQ when out_ep_data_avail=1; out_ep_req=1 in REQ, XFER and FLUSH, and 0 in IDLE.
REQ-022 REQ -> XFER when out_ep_grant=1.
REQ-023 In XFER, out_ep_data_get=1 exactly in cycles where all of the following hold:
- out_ep_grant=1
- out_ep_data_avail=1
- fifo_level + inflight < FIFO_DEPTH
REQ-024 inflight is 1 in the cycle after a get, otherwise 0.
REQ-025 The byte arriving on out_ep_data in the cycle after a get is written to the FIFO in that cycle.
REQ-026 Captured bytes are not written to the FIFO if out_ep_setup=1; in that case setup_seen is set to 1.
REQ-027 XFER -> FLUSH when out_ep_data_avail=0, or when out_ep_grant drops.
REQ-028 FLUSH lasts exactly one cycle, capturing the last in-flight byte while out_ep_req stays high, then returns to IDLE.
REQ-029 If grant drops while in XFER, no get is issued; any in-flight byte is still captured in FLUSH.
REQ-030 FIFO is a circular buffer of FIFO_DEPTH bytes.
REQ-031 FIFO pointers are $clog2(FIFO_DEPTH)+1 bits wide, using the MSB for full/empty disambiguation and wrapping naturally.
REQ-032 A simultaneous FIFO write and pop shall leave fifo_level unchanged and lose no data.
REQ-033 uart_data shall be combinationally driven from the head entry; zero-latency show-ahead.
REQ-034 pkt_count increments on out_ep_acked and wraps from 0xFFFF to 0.
REQ-035 out_ep_stall = ENABLE_STALL && stall_req.
REQ-036 Overflow is impossible by construction; a write to a full FIFO is a verification failure.

Reset
REQ-037 When reset_n=0 at a clock edge, the following take these values on that edge regardless of FSM state:
- FSM -> IDLE
- FIFO pointers, fifo_level, pkt_count and setup_seen -> 0
- out_ep_req, out_ep_data_get and uart_valid -> 0
REQ-038 Any in-flight byte is discarded on reset.
REQ-039 FIFO storage array is not reset.

Structure
REQ-040 FSM state encoding, the PID-independent endpoint constants and the FIFO_DEPTH default belong in the shared usb_serial package.
REQ-041 FIFO is a separate sub-module, usb_serial_sync_fifo (parameterised depth and width, show-ahead); the FSM stays in usb_serial_out_ep.

Verification
REQ-042 Scenario: 8-byte packet 0x01..0x08, grant given 2 cycles after req, uart_ready=1 -> bytes appear in order on uart_data, 8 gets issued, FSM returns to IDLE, pkt_count=1.
REQ-043 Scenario: 32-byte packet with FIFO_DEPTH=16 and uart_ready=0 -> exactly 16 gets, fifo_level=16, out_ep_req stays high; raising uart_ready drains all 32 bytes in order.
REQ-044 Scenario: grant deasserted mid-packet after byte 3 -> in-flight byte 3 is captured, gets stop; grant restored -> bytes 4..N follow with no duplicates or gaps.
REQ-045 Scenario: SETUP packet of 8 bytes -> FIFO unchanged, setup_seen=1.
REQ-046 Scenario: reset_n pulsed low during XFER with fifo_level=5 -> next cycle fifo_level=0, uart_valid=0, out_ep_req=0.
REQ-047 Scenario: 70000 acked strobes -> pkt_count = 70000 mod 65536 = 4464.
